riscv_core_mul_issue: RTL and testbench

// - Sequential issue/retire stage directly upstream of the combinational riscv_core_mul (instantiated inside).
// - Accepts M-extension multiply ops from execute via valid/ready, decodes funct3/isword into i_mul_control/i_mul_isword.
// - Holds operands stable for MUL_LAT cycles (multicycle path), captures the 64-bit result, returns it to writeback via valid/ready.

---
 rtl/riscv_core_mul_issue.sv | 241 ++++++++++++++++++++++++
 tb/tb_riscv_core_mul_issue.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_mul_issue.sv
// Multiply issue/retire stage wrapped around the combinational riscv_core_mul.
// Define RISCV_MUL_REPEAT_EN to cache the last retired op and return repeats without a multiply.

module riscv_core_mul #(
  parameter int XLEN = 64
) (
  input  logic [1:0]      i_mul_control,
  input  logic            i_mul_isword,
  input  logic [XLEN-1:0] i_mul_srcA,
  input  logic [XLEN-1:0] i_mul_srcB,
  output logic [XLEN-1:0] o_mul_result
);
  logic [XLEN:0]     a_ext_s;
  logic [XLEN:0]     b_ext_s;
  logic [2*XLEN-1:0] a_wide_s;
  logic [2*XLEN-1:0] b_wide_s;
  logic [2*XLEN-1:0] prod_s;
  logic [31:0]       word_prod_s;

  // Sign-extend per control, multiply modulo 2^(2*XLEN) and select the half or word result
  always_comb begin
    a_ext_s = {1'b0, i_mul_srcA};
    b_ext_s = {1'b0, i_mul_srcB};
    case (i_mul_control)
      2'b01: begin
        a_ext_s = {i_mul_srcA[XLEN-1], i_mul_srcA};
        b_ext_s = {i_mul_srcB[XLEN-1], i_mul_srcB};
      end
      2'b10: begin
        a_ext_s = {i_mul_srcA[XLEN-1], i_mul_srcA};
        b_ext_s = {1'b0, i_mul_srcB};
      end
      default: begin
        a_ext_s = {1'b0, i_mul_srcA};
        b_ext_s = {1'b0, i_mul_srcB};
      end
    endcase
    a_wide_s    = {{(XLEN-1){a_ext_s[XLEN]}}, a_ext_s};
    b_wide_s    = {{(XLEN-1){b_ext_s[XLEN]}}, b_ext_s};
    prod_s      = a_wide_s * b_wide_s;
    word_prod_s = i_mul_srcA[31:0] * i_mul_srcB[31:0];
    if (i_mul_isword) begin
      o_mul_result = {{(XLEN-32){word_prod_s[31]}}, word_prod_s};
    end else if (i_mul_control == 2'b00) begin
      o_mul_result = prod_s[XLEN-1:0];
    end else begin
      o_mul_result = prod_s[2*XLEN-1:XLEN];
    end
  end
endmodule

module riscv_core_mul_issue #(
  parameter int XLEN    = 64,
  parameter int MUL_LAT = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mul_valid,
  output logic            o_mul_ready,
  input  logic [2:0]      i_mul_funct3,
  input  logic            i_mul_isword,
  input  logic [XLEN-1:0] i_mul_srcA,
  input  logic [XLEN-1:0] i_mul_srcB,
  input  logic [4:0]      i_mul_rd,
  input  logic            i_flush,
  output logic            o_wb_valid,
  input  logic            i_wb_ready,
  output logic [XLEN-1:0] o_wb_result,
  output logic [4:0]      o_wb_rd,
  output logic            o_wb_err,
  output logic            o_mul_busy
);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(MUL_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wb_valid_q, busy_q;
  logic [XLEN-1:0] src_a_q, src_b_q;
  logic [1:0]      ctrl_q;
  logic            isword_q, ill_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] wb_result_q;
  logic [4:0]      wb_rd_q;
  logic            wb_err_q;

  logic            ready_s, accept_s, illegal_s, capture_s, retire_s, hit_s;
  logic [XLEN-1:0] mul_result_s;

  assign illegal_s = i_mul_funct3[2] | (i_mul_isword & (i_mul_funct3 != 3'b000));
  assign accept_s  = i_mul_valid & ready_s;
  assign capture_s = (state_q == ST_BUSY) & (cnt_q == {CW{1'b0}}) & ~i_flush;
  assign retire_s  = (state_q == ST_DONE) & i_wb_ready;

  riscv_core_mul #(.XLEN(XLEN)) u_mul (
    .i_mul_control (ctrl_q),
    .i_mul_isword  (isword_q),
    .i_mul_srcA    (src_a_q),
    .i_mul_srcB    (src_b_q),
    .o_mul_result  (mul_result_s)
  );

`ifdef RISCV_MUL_REPEAT_EN
  logic            c_vld_q, c_iw_q, c_err_q, iw_raw_q;
  logic [2:0]      c_f3_q, f3_raw_q;
  logic [XLEN-1:0] c_a_q, c_b_q, c_res_q;

  assign hit_s = c_vld_q & (i_mul_funct3 == c_f3_q) & (i_mul_isword == c_iw_q) &
                 (i_mul_srcA == c_a_q) & (i_mul_srcB == c_b_q);

  // Raw encoding of the op in flight, kept so a retiring op can be cached as seen by execute
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      f3_raw_q <= 3'b000;
      iw_raw_q <= 1'b0;
    end else if (accept_s) begin
      f3_raw_q <= i_mul_funct3;
      iw_raw_q <= i_mul_isword;
    end
  end

  // Last retired op; a flush invalidates it because the retiring context may be squashed
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      c_vld_q <= 1'b0;
      c_f3_q  <= 3'b000;
      c_iw_q  <= 1'b0;
      c_a_q   <= {XLEN{1'b0}};
      c_b_q   <= {XLEN{1'b0}};
      c_res_q <= {XLEN{1'b0}};
      c_err_q <= 1'b0;
    end else if (i_flush) begin
      c_vld_q <= 1'b0;
    end else if (retire_s) begin
      c_vld_q <= 1'b1;
      c_f3_q  <= f3_raw_q;
      c_iw_q  <= iw_raw_q;
      c_a_q   <= src_a_q;
      c_b_q   <= src_b_q;
      c_res_q <= wb_result_q;
      c_err_q <= wb_err_q;
    end
  end
`else
  assign hit_s = 1'b0;
`endif

  // State register with registered valid/busy derived from the next state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      wb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= (state_d == ST_DONE);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic; accept can only fire from IDLE or from DONE while retiring
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = {CW{1'b0}};
    end else if (accept_s) begin
      state_d = hit_s ? ST_DONE : ST_BUSY;
      cnt_d   = LAT_M1;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_BUSY: begin
          if (cnt_q == {CW{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_DONE: state_d = i_wb_ready ? ST_IDLE : ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: ready is combinational so a retire and a new issue share one edge
  always_comb begin
    ready_s = ((state_q == ST_IDLE) | ((state_q == ST_DONE) & i_wb_ready)) & ~i_flush;
  end

  // Operand/control capture only on accept keeps the multiplier inputs stable across BUSY
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      src_a_q  <= {XLEN{1'b0}};
      src_b_q  <= {XLEN{1'b0}};
      ctrl_q   <= 2'b00;
      isword_q <= 1'b0;
      ill_q    <= 1'b0;
      rd_q     <= 5'd0;
    end else if (accept_s) begin
      src_a_q  <= i_mul_srcA;
      src_b_q  <= i_mul_srcB;
      ctrl_q   <= illegal_s ? 2'b00 : i_mul_funct3[1:0];
      isword_q <= i_mul_isword & ~illegal_s;
      ill_q    <= illegal_s;
      rd_q     <= i_mul_rd;
    end
  end

  // Writeback payload, held unchanged while DONE waits for the consumer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wb_result_q <= {XLEN{1'b0}};
      wb_rd_q     <= 5'd0;
      wb_err_q    <= 1'b0;
    end else if (capture_s) begin
      wb_result_q <= ill_q ? {XLEN{1'b0}} : mul_result_s;
      wb_rd_q     <= rd_q;
      wb_err_q    <= ill_q;
    end
`ifdef RISCV_MUL_REPEAT_EN
    else if (accept_s & hit_s) begin
      wb_result_q <= c_res_q;
      wb_rd_q     <= i_mul_rd;
      wb_err_q    <= c_err_q;
    end
`endif
  end

  assign o_mul_ready = ready_s;
  assign o_wb_valid  = wb_valid_q;
  assign o_wb_result = wb_result_q;
  assign o_wb_rd     = wb_rd_q;
  assign o_wb_err    = wb_err_q;
  assign o_mul_busy  = busy_q;
endmodule

// File: tb/tb_riscv_core_mul_issue.sv
// Directed bench for riscv_core_mul_issue: transaction-level model checked every cycle plus literal expectations.
module tb_riscv_core_mul_issue;
  localparam int XLEN = 64;
  localparam int MUL_LAT = 2;
`ifdef RISCV_MUL_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic clk, rst, mul_valid, isword, flush, wb_ready;
  logic [2:0] funct3;
  logic [63:0] src_a, src_b;
  logic [4:0] rd;
  logic mul_ready, wb_valid, wb_err, busy;
  logic [63:0] wb_result;
  logic [4:0] wb_rd;

  int checks = 0;
  int errors = 0;

  riscv_core_mul_issue #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_mul_valid(mul_valid), .o_mul_ready(mul_ready),
    .i_mul_funct3(funct3), .i_mul_isword(isword), .i_mul_srcA(src_a), .i_mul_srcB(src_b),
    .i_mul_rd(rd), .i_flush(flush), .o_wb_valid(wb_valid), .i_wb_ready(wb_ready),
    .o_wb_result(wb_result), .o_wb_rd(wb_rd), .o_wb_err(wb_err), .o_mul_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit pend; int due; logic [2:0] p_f3; bit p_iw; logic [63:0] p_a, p_b; logic [4:0] p_rd;
    bit valid; logic [63:0] res; logic [4:0] vrd; bit err;
    logic [2:0] v_f3; bit v_iw; logic [63:0] v_a, v_b;
    bit cvld; logic [2:0] c_f3; bit c_iw; logic [63:0] c_a, c_b, c_res; bit c_err;
  } model_t;

  model_t mdl;
  int ecnt;

  function automatic logic [64:0] ref_mul(input logic [2:0] f, input logic iw,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [127:0] wa, wb, p;
    logic [31:0] lo;
    if (f[2] || (iw && f != 3'b000)) return {1'b1, 64'h0};
    if (iw) begin
      lo = a[31:0] * b[31:0];
      return {1'b0, {{32{lo[31]}}, lo}};
    end
    wa = (f == 3'b001 || f == 3'b010) ? {{64{a[63]}}, a} : {64'h0, a};
    wb = (f == 3'b001) ? {{64{b[63]}}, b} : {64'h0, b};
    p = wa * wb;
    if (f == 3'b000) return {1'b0, p[63:0]};
    return {1'b0, p[127:64]};
  endfunction

  function automatic bit model_ready(input model_t m, input logic fl, input logic wr);
    return ((!m.pend && !m.valid) || (m.valid && wr)) && !fl;
  endfunction

  function automatic model_t model_step(input model_t m, input int e, input logic v,
      input logic [2:0] f, input logic iw, input logic [63:0] a, input logic [63:0] b,
      input logic [4:0] r, input logic fl, input logic wr);
    model_t n = m;
    logic [64:0] rv;
    bit acc = v && model_ready(m, fl, wr);
    if (fl) begin
      n.pend = 0; n.valid = 0; n.cvld = 0;
      return n;
    end
    if (m.valid && wr) begin
      n.valid = 0; n.cvld = 1;
      n.c_f3 = m.v_f3; n.c_iw = m.v_iw; n.c_a = m.v_a; n.c_b = m.v_b;
      n.c_res = m.res; n.c_err = m.err;
    end
    if (m.pend && e == m.due) begin
      rv = ref_mul(m.p_f3, m.p_iw, m.p_a, m.p_b);
      n.pend = 0; n.valid = 1; n.res = rv[63:0]; n.err = rv[64]; n.vrd = m.p_rd;
      n.v_f3 = m.p_f3; n.v_iw = m.p_iw; n.v_a = m.p_a; n.v_b = m.p_b;
    end
    if (acc) begin
      if (REPEAT && m.cvld && f == m.c_f3 && iw == m.c_iw && a == m.c_a && b == m.c_b) begin
        n.valid = 1; n.res = m.c_res; n.err = m.c_err; n.vrd = r;
        n.v_f3 = f; n.v_iw = iw; n.v_a = a; n.v_b = b;
      end else begin
        n.pend = 1; n.due = e + MUL_LAT;
        n.p_f3 = f; n.p_iw = iw; n.p_a = a; n.p_b = b; n.p_rd = r;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl  <= '{default: '0};
      ecnt <= 0;
    end else begin
      mdl  <= model_step(mdl, ecnt, mul_valid, funct3, isword, src_a, src_b, rd, flush, wb_ready);
      ecnt <= ecnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: DUT against model on every out-of-reset cycle
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_ready", 64'(mul_ready), 64'(model_ready(mdl, flush, wb_ready)));
      chk("m_valid", 64'(wb_valid), 64'(mdl.valid));
      chk("m_busy", 64'(busy), 64'(mdl.pend | mdl.valid));
      if (mdl.valid) begin
        chk("m_result", wb_result, mdl.res);
        chk("m_rd", 64'(wb_rd), 64'(mdl.vrd));
        chk("m_err", 64'(wb_err), 64'(mdl.err));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic offer(input logic [2:0] f, input logic iw, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] r);
    mul_valid = 1'b1; funct3 = f; isword = iw; src_a = a; src_b = b; rd = r;
  endtask

  task automatic wait_accept(input string nm);
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mul_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_accept: ready never seen within 20 cycles", nm);
    end
    @(posedge clk); #1;
    mul_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (wb_valid) begin n = k; break; end
    end
    if (n == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: o_wb_valid not seen within 20 cycles", nm);
    end
  endtask

  task automatic expect_out(input string nm, input logic [63:0] res, input logic [4:0] r,
                            input logic e);
    chk({nm, "_result"}, wb_result, res);
    chk({nm, "_rd"}, 64'(wb_rd), 64'(r));
    chk({nm, "_err"}, 64'(wb_err), 64'(e));
  endtask

  task automatic retire();
    @(posedge clk); #1 wb_ready = 1'b1;
    @(posedge clk); #1 wb_ready = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f, input logic iw,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] r,
                        input logic [63:0] res, input logic e, input int lat);
    int n;
    offer(f, iw, a, b, r);
    wait_accept(nm);
    wait_valid(nm, n);
    chk({nm, "_lat"}, 64'(n), 64'(lat));
    expect_out(nm, res, r, e);
    retire();
  endtask

  initial begin
    int n;
    rst = 1'b1; mul_valid = 1'b0; funct3 = 3'b000; isword = 1'b0; src_a = 64'h0;
    src_b = 64'h0; rd = 5'd0; flush = 1'b0; wb_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(wb_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ready", 64'(mul_ready), 64'h1);
    expect_out("rst", 64'h0, 5'd0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // MUL 3*5, latency, hold with wb_ready low, then back-to-back issue
    offer(3'b000, 1'b0, 64'd3, 64'd5, 5'd7);
    wait_accept("mul35");
    wait_valid("mul35", n);
    chk("mul35_lat", 64'(n), 64'(MUL_LAT + 1));
    expect_out("mul35", 64'h000000000000000F, 5'd7, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(wb_valid), 64'h1);
      expect_out("hold", 64'h000000000000000F, 5'd7, 1'b0);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    offer(3'b001, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd1);
    @(negedge clk);
    chk("b2b_ready", 64'(mul_ready), 64'h1);
    @(posedge clk); #1;
    wb_ready = 1'b0; mul_valid = 1'b0;
    wait_valid("mulh", n);
    chk("mulh_lat", 64'(n), 64'(MUL_LAT + 1));
    expect_out("mulh", 64'h0, 5'd1, 1'b0);
    retire();

    run_op("mulhu", 3'b011, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd2,
           64'hFFFFFFFFFFFFFFFE, 1'b0, MUL_LAT + 1);
    run_op("mulhsu", 3'b010, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd3,
           64'hFFFFFFFFFFFFFFFF, 1'b0, MUL_LAT + 1);
    run_op("mulw", 3'b000, 1'b1, 64'h000000007FFFFFFF, 64'd2, 5'd4,
           64'hFFFFFFFFFFFFFFFE, 1'b0, MUL_LAT + 1);
    run_op("ill_w", 3'b001, 1'b1, 64'd3, 64'd5, 5'd5, 64'h0, 1'b1, MUL_LAT + 1);
    run_op("ill_f3", 3'b100, 1'b0, 64'd3, 64'd5, 5'd6, 64'h0, 1'b1, MUL_LAT + 1);
    run_op("mul_m1x3", 3'b000, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd3, 5'd8,
           64'hFFFFFFFFFFFFFFFD, 1'b0, MUL_LAT + 1);
    run_op("mul_m7x6", 3'b000, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd6, 5'd9,
           64'hFFFFFFFFFFFFFFD6, 1'b0, MUL_LAT + 1);

    // Flush while BUSY: no result ever appears
    offer(3'b000, 1'b0, 64'd3, 64'd5, 5'd9);
    wait_accept("flush_busy");
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("flush_novalid", 64'(wb_valid), 64'h0);
    end

    // Op offered during a flush cycle is refused
    @(posedge clk); #1;
    flush = 1'b1;
    offer(3'b000, 1'b0, 64'd3, 64'd5, 5'd10);
    @(negedge clk);
    chk("flush_ready", 64'(mul_ready), 64'h0);
    @(posedge clk); #1;
    flush = 1'b0; mul_valid = 1'b0;
    @(negedge clk);
    chk("flush_noacc_busy", 64'(busy), 64'h0);

    // Flush in DONE together with wb_ready: retires, then idle
    @(posedge clk); #1;
    offer(3'b000, 1'b0, 64'd2, 64'd2, 5'd11);
    wait_accept("flush_done");
    wait_valid("flush_done", n);
    expect_out("flush_done", 64'd4, 5'd11, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1; wb_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; wb_ready = 1'b0;
    @(negedge clk);
    chk("flush_done_valid", 64'(wb_valid), 64'h0);
    chk("flush_done_busy", 64'(busy), 64'h0);

    // Same op twice: the repeat is served from the cache when enabled
    @(posedge clk); #1;
    run_op("mul35_a", 3'b000, 1'b0, 64'd3, 64'd5, 5'd12, 64'h000000000000000F, 1'b0,
           MUL_LAT + 1);
    run_op("mul35_rep", 3'b000, 1'b0, 64'd3, 64'd5, 5'd13, 64'h000000000000000F, 1'b0,
           REPEAT ? 1 : MUL_LAT + 1);

    // Asynchronous reset in the middle of BUSY
    offer(3'b000, 1'b0, 64'd3, 64'd5, 5'd14);
    wait_accept("rst_mid");
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(wb_valid), 64'h0);
    chk("rst_mid_busy", 64'(busy), 64'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 64'(mul_ready), 64'h1);
    chk("rst_mid_busy2", 64'(busy), 64'h0);
    @(posedge clk); #1;
    run_op("post_rst", 3'b000, 1'b0, 64'd3, 64'd5, 5'd15, 64'h000000000000000F, 1'b0,
           MUL_LAT + 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
